// File: rtl/rca_serial_if.sv
// Operand/result handshake bundle for rca_serial.
// The ovf wire exists only when RCA_SERIAL_OVF_EN is defined.
interface rca_serial_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef RCA_SERIAL_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, cin, out_ready,
`ifdef RCA_SERIAL_OVF_EN
    input  ovf,
`endif
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
`ifdef RCA_SERIAL_OVF_EN
    output ovf,
`endif
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/rca_serial.sv
// Multi-cycle ripple-carry adder: DIGIT bits of a+b+cin per clock over WIDTH/DIGIT steps.
// Optional signed-overflow output enabled by RCA_SERIAL_OVF_EN.
//
// state | meaning
// IDLE  | in_ready=1, waiting for operands
// CALC  | one DIGIT-bit slice added per cycle, LSB digit first
// DONE  | out_valid=1, result held until out_ready
module rca_serial #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  rca_serial_if.slave bus
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, sum_q, sum_nxt;
  logic             carry, cout_q;
  logic [CW-1:0]    cnt;
  logic [DIGIT:0]   slice;
  logic             accept, step, last, in_ready, out_valid;

  assign slice = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
  assign last  = (cnt == CW'(N - 1));

  // Completed digits collect in the top of sum_sh; the final digit lands above them.
  generate
    if (N == 1) begin : g_single
      assign sum_nxt = slice[DIGIT-1:0];
    end else begin : g_multi
      logic [WIDTH-DIGIT-1:0] sum_sh;
      assign sum_nxt = {slice[DIGIT-1:0], sum_sh};
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    sum_sh <= '0;
        else if (step) sum_sh <= sum_nxt[WIDTH-1:DIGIT];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (accept) begin
      a_sh  <= bus.a;
      b_sh  <= bus.b;
      carry <= bus.cin;
      cnt   <= '0;
    end else if (step) begin
      a_sh  <= a_sh >> DIGIT;
      b_sh  <= b_sh >> DIGIT;
      carry <= slice[DIGIT];
      if (last) begin
        sum_q  <= sum_nxt;
        cout_q <= slice[DIGIT];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef RCA_SERIAL_OVF_EN
  logic a_msb, b_msb, ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      a_msb <= bus.a[WIDTH-1];
      b_msb <= bus.b[WIDTH-1];
    end else if (step && last) begin
      ovf_q <= (a_msb == b_msb) && (sum_nxt[WIDTH-1] != a_msb);
    end
  end

  assign bus.ovf = ovf_q;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
endmodule

// File: tb/tb_rca_serial.sv
// Bench for rca_serial: an 8-bit/2-bit-digit instance and an 8-bit/8-bit-digit instance.
// Expected results come from plain integer arithmetic on the operands.
module tb_rca_serial;
  localparam int N0 = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  rca_serial_if #(.WIDTH(8)) bus0 ();
  rca_serial_if #(.WIDTH(8)) bus1 ();

  rca_serial #(.WIDTH(8), .DIGIT(2)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  rca_serial #(.WIDTH(8), .DIGIT(8)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  // {ovf, cout, sum} for a+b+c
  function automatic logic [9:0] ref_add(input logic [7:0] a, input logic [7:0] b, input logic c);
    int   s;
    int   ss;
    logic ov;
    s  = int'(a) + int'(b) + int'(c);
    ss = int'($signed(a)) + int'($signed(b)) + int'(c);
    ov = (ss > 127) || (ss < -128);
    return {ov, s[8], s[7:0]};
  endfunction

  task automatic send0(input logic [7:0] a, input logic [7:0] b, input logic c);
    bus0.a = a; bus0.b = b; bus0.cin = c; bus0.in_valid = 1'b1;
    @(posedge clk); #1;
    bus0.in_valid = 1'b0;
  endtask

  task automatic wait_valid0(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (bus0.out_valid) begin
        lat = k;
        return;
      end
    end
  endtask

  task automatic consume0();
    bus0.out_ready = 1'b1;
    @(posedge clk); #1;
    bus0.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus0.in_valid = 0; bus0.a = 0; bus0.b = 0; bus0.cin = 0; bus0.out_ready = 0;
    bus1.in_valid = 0; bus1.a = 0; bus1.b = 0; bus1.cin = 0; bus1.out_ready = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus0.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", bus0.in_ready); else passes++;
    checks++; if (bus0.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", bus0.out_valid); else passes++;
    checks++; if (bus0.sum !== 8'h00) $display("FAIL reset_sum got %h exp 00", bus0.sum); else passes++;
    checks++; if (bus0.cout !== 1'b0) $display("FAIL reset_cout got %b exp 0", bus0.cout); else passes++;
    checks++; if (bus1.in_ready !== 1'b1) $display("FAIL reset_in_ready_fw got %b exp 1", bus1.in_ready); else passes++;
`ifdef RCA_SERIAL_OVF_EN
    checks++; if (bus0.ovf !== 1'b0) $display("FAIL reset_ovf got %b exp 0", bus0.ovf); else passes++;
`endif
  endtask

  task automatic test_basic();
    int lat;
    send0(8'h5A, 8'h3C, 1'b0);
    wait_valid0(lat);
    checks++; if (lat !== N0) $display("FAIL basic_latency got %0d exp %0d", lat, N0); else passes++;
    checks++; if (bus0.sum !== 8'h96) $display("FAIL basic_sum got %h exp 96", bus0.sum); else passes++;
    checks++; if (bus0.cout !== 1'b0) $display("FAIL basic_cout got %b exp 0", bus0.cout); else passes++;
    checks++; if (bus0.in_ready !== 1'b0) $display("FAIL basic_done_in_ready got %b exp 0", bus0.in_ready); else passes++;
    consume0();
    checks++; if (bus0.out_valid !== 1'b0) $display("FAIL basic_out_valid_drop got %b exp 0", bus0.out_valid); else passes++;
    checks++; if (bus0.in_ready !== 1'b1) $display("FAIL basic_back_idle got %b exp 1", bus0.in_ready); else passes++;
  endtask

  task automatic test_carry_ovf();
    logic [16:0] vec [4] = '{{8'hFF, 8'h01, 1'b1}, {8'h7F, 8'h01, 1'b0},
                             {8'h80, 8'h80, 1'b0}, {8'h7F, 8'h00, 1'b1}};
    logic [9:0]  exp;
    int          lat;
    foreach (vec[i]) begin
      exp = ref_add(vec[i][16:9], vec[i][8:1], vec[i][0]);
      send0(vec[i][16:9], vec[i][8:1], vec[i][0]);
      wait_valid0(lat);
      checks++; if (bus0.sum !== exp[7:0]) $display("FAIL carry_sum[%0d] got %h exp %h", i, bus0.sum, exp[7:0]); else passes++;
      checks++; if (bus0.cout !== exp[8]) $display("FAIL carry_cout[%0d] got %b exp %b", i, bus0.cout, exp[8]); else passes++;
`ifdef RCA_SERIAL_OVF_EN
      checks++; if (bus0.ovf !== exp[9]) $display("FAIL carry_ovf[%0d] got %b exp %b", i, bus0.ovf, exp[9]); else passes++;
`endif
      consume0();
    end
  endtask

  task automatic test_backpressure();
    logic [9:0] exp;
    int         lat;
    exp = ref_add(8'h21, 8'h43, 1'b1);
    send0(8'h21, 8'h43, 1'b1);
    wait_valid0(lat);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        bus0.a = 8'h11; bus0.b = 8'h00; bus0.in_valid = 1'b1;
      end else begin
        bus0.in_valid = 1'b0;
      end
      @(posedge clk); #1;
      checks++; if (bus0.out_valid !== 1'b1) $display("FAIL stall_out_valid[%0d] got %b exp 1", i, bus0.out_valid); else passes++;
      checks++; if (bus0.in_ready !== 1'b0) $display("FAIL stall_in_ready[%0d] got %b exp 0", i, bus0.in_ready); else passes++;
      checks++; if (bus0.sum !== exp[7:0]) $display("FAIL stall_sum[%0d] got %h exp %h", i, bus0.sum, exp[7:0]); else passes++;
    end
    bus0.in_valid = 1'b0;
    consume0();
    checks++; if (bus0.out_valid !== 1'b0) $display("FAIL release_out_valid got %b exp 0", bus0.out_valid); else passes++;
    checks++; if (bus0.in_ready !== 1'b1) $display("FAIL release_in_ready got %b exp 1", bus0.in_ready); else passes++;
    checks++; if (bus0.sum !== exp[7:0]) $display("FAIL release_sum_kept got %h exp %h", bus0.sum, exp[7:0]); else passes++;
    @(posedge clk); #1;
    checks++; if (bus0.in_ready !== 1'b1) $display("FAIL ignored_input_idle got %b exp 1", bus0.in_ready); else passes++;
  endtask

  task automatic test_abort();
    bit rose = 1'b0;
    send0(8'h12, 8'h34, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++; if (bus0.out_valid !== 1'b0) $display("FAIL abort_out_valid got %b exp 0", bus0.out_valid); else passes++;
    checks++; if (bus0.sum !== 8'h00) $display("FAIL abort_sum got %h exp 00", bus0.sum); else passes++;
    checks++; if (bus0.in_ready !== 1'b1) $display("FAIL abort_idle got %b exp 1", bus0.in_ready); else passes++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus0.out_valid) rose = 1'b1;
    end
    checks++; if (rose !== 1'b0) $display("FAIL abort_no_pulse got %b exp 0", rose); else passes++;
  endtask

  task automatic test_full_width();
    logic [7:0] a, b;
    logic       c;
    logic [9:0] exp;
    int         lat;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin
        a = 8'h80; b = 8'h80; c = 1'b0;
      end else begin
        a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
      end
      exp = ref_add(a, b, c);
      bus1.a = a; bus1.b = b; bus1.cin = c; bus1.in_valid = 1'b1;
      @(posedge clk); #1;
      bus1.in_valid = 1'b0;
      lat = -1;
      for (int k = 1; k <= 10 && lat < 0; k++) begin
        @(posedge clk); #1;
        if (bus1.out_valid) lat = k;
      end
      checks++; if (lat !== 1) $display("FAIL fw_latency[%0d] got %0d exp 1", i, lat); else passes++;
      checks++; if (bus1.sum !== exp[7:0]) $display("FAIL fw_sum[%0d] got %h exp %h", i, bus1.sum, exp[7:0]); else passes++;
      checks++; if (bus1.cout !== exp[8]) $display("FAIL fw_cout[%0d] got %b exp %b", i, bus1.cout, exp[8]); else passes++;
`ifdef RCA_SERIAL_OVF_EN
      checks++; if (bus1.ovf !== exp[9]) $display("FAIL fw_ovf[%0d] got %b exp %b", i, bus1.ovf, exp[9]); else passes++;
`endif
      bus1.out_ready = 1'b1;
      @(posedge clk); #1;
      bus1.out_ready = 1'b0;
    end
  endtask

  task automatic test_random();
    logic [9:0] exp = '0;
    int         cyc = 0, acc_cyc = 0, done = 0;
    bit         seen = 1'b1;
    bus0.a = 8'($urandom); bus0.b = 8'($urandom); bus0.cin = 1'($urandom);
    bus0.in_valid = 1'b1;
    while (done < 40 && cyc < 3000) begin
      @(negedge clk); cyc++;
      bus0.out_ready = 1'($urandom_range(0, 1));
      if (bus0.in_ready && bus0.in_valid) begin
        exp = ref_add(bus0.a, bus0.b, bus0.cin);
        acc_cyc = cyc;
        seen = 1'b0;
      end
      if (bus0.out_valid) begin
        if (!seen) begin
          seen = 1'b1;
          done++;
          checks++; if (cyc - acc_cyc - 1 !== N0) $display("FAIL rand_latency got %0d exp %0d", cyc - acc_cyc - 1, N0); else passes++;
        end
        checks++; if (bus0.sum !== exp[7:0]) $display("FAIL rand_sum got %h exp %h", bus0.sum, exp[7:0]); else passes++;
        checks++; if (bus0.cout !== exp[8]) $display("FAIL rand_cout got %b exp %b", bus0.cout, exp[8]); else passes++;
`ifdef RCA_SERIAL_OVF_EN
        checks++; if (bus0.ovf !== exp[9]) $display("FAIL rand_ovf got %b exp %b", bus0.ovf, exp[9]); else passes++;
`endif
      end
      @(posedge clk); #1;
      bus0.a = 8'($urandom); bus0.b = 8'($urandom); bus0.cin = 1'($urandom);
      bus0.in_valid = ($urandom_range(0, 3) != 0);
    end
    checks++; if (done < 40) $display("FAIL rand_timeout got %0d results exp 40", done); else passes++;
    bus0.in_valid = 1'b0;
    bus0.out_ready = 1'b1;
    repeat (N0 + 4) @(posedge clk);
    #1 bus0.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp = '0;
    int         cyc = 0, prev_acc = -1, done = 0;
    bus0.out_ready = 1'b1;
    bus0.a = 8'($urandom); bus0.b = 8'($urandom); bus0.cin = 1'($urandom);
    bus0.in_valid = 1'b1;
    while (done < 6 && cyc < 200) begin
      @(negedge clk); cyc++;
      if (bus0.out_valid) begin
        done++;
        checks++; if (bus0.sum !== exp[7:0]) $display("FAIL b2b_sum got %h exp %h", bus0.sum, exp[7:0]); else passes++;
        checks++; if (bus0.cout !== exp[8]) $display("FAIL b2b_cout got %b exp %b", bus0.cout, exp[8]); else passes++;
      end
      if (bus0.in_ready) begin
        if (prev_acc >= 0) begin
          checks++; if (cyc - prev_acc !== N0 + 2) $display("FAIL b2b_interval got %0d exp %0d", cyc - prev_acc, N0 + 2); else passes++;
        end
        prev_acc = cyc;
        exp = ref_add(bus0.a, bus0.b, bus0.cin);
        @(posedge clk); #1;
        bus0.a = 8'($urandom); bus0.b = 8'($urandom); bus0.cin = 1'($urandom);
      end
    end
    checks++; if (done < 6) $display("FAIL b2b_timeout got %0d results exp 6", done); else passes++;
    bus0.in_valid = 1'b0;
    repeat (N0 + 4) @(posedge clk);
    #1 bus0.out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_ovf();
    test_backpressure();
    test_abort();
    test_full_width();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
